// File: rtl/boot_pkg.sv
// Shared types for the boot loader: FSM state encoding and frame-length constants.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN,
        DATA,
        SUM,
        RUN,
        ERROR
    } boot_state_t;

    // A length byte of zero encodes a full 256-byte payload.
    localparam logic [8:0] LEN_ZERO_MEANS = 9'd256;

endpackage

// File: rtl/boot_bus_mux.sv
// Single-master select on the 8-bit memory bus: CPU when it owns the bus, loader otherwise.
// Purely combinational, zero latency; no backpressure.
module boot_bus_mux (
    input  logic       cpu_owns,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    input  logic [7:0] ldr_addr,
    input  logic [7:0] ldr_wdata,
    input  logic       ldr_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we
);

    assign mem_addr  = cpu_owns ? cpu_addr  : ldr_addr;
    assign mem_wdata = cpu_owns ? cpu_wdata : ldr_wdata;
    assign mem_we    = cpu_owns ? cpu_we    : ldr_we;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives length/payload/checksum frame, writes program memory, then releases the CPU.
// Memory write in the same cycle as each payload handshake; rx_ready drops outside load states and on load_req.
module boot_loader
    import boot_pkg::*;
#(
    parameter bit SKIP_LOAD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_req,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       cpu_reset,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    output logic [7:0] cpu_rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       load_err,
    output logic       loading
);

    localparam boot_state_t RESET_STATE = SKIP_LOAD ? RUN : LEN;

    boot_state_t state_q, state_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;

    logic        acc;
    logic        cpu_owns;
    logic        ldr_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    // load_req wins over any byte offered in the same cycle; rx_ready is already low then.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        if (load_req) begin
            state_d = LEN;
        end else if (acc) begin
            case (state_q)
                LEN: begin
                    len_d   = (rx_data == 8'd0) ? LEN_ZERO_MEANS : {1'b0, rx_data};
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = DATA;
                end
                DATA: begin
                    sum_d = sum_q + rx_data;
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q + 9'd1 == len_q) begin
                        state_d = SUM;
                    end
                end
                SUM: begin
                    state_d = (rx_data == sum_q) ? RUN : ERROR;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        loading  = 1'b0;
        load_err = 1'b0;
        cpu_owns = 1'b0;
        case (state_q)
            LEN, DATA, SUM: loading  = 1'b1;
            RUN:            cpu_owns = 1'b1;
            ERROR:          load_err = 1'b1;
            default: begin
            end
        endcase
    end

    assign rx_ready  = loading & ~load_req;
    assign acc       = rx_valid & rx_ready;
    assign ldr_we    = (state_q == DATA) & acc;
    assign cpu_reset = ~cpu_owns;
    assign cpu_rdata = mem_rdata;

    boot_bus_mux u_bus_mux (
        .cpu_owns  (cpu_owns),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .ldr_addr  (cnt_q[7:0]),
        .ldr_wdata (rx_data),
        .ldr_we    (ldr_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed frames from the test plan plus random frames against a memory-image model.
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_req;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       cpu_reset;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_we;
    logic [7:0] cpu_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       load_err;
    logic       loading;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] pl      [256];

    always #5 clk = ~clk;

    // Memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    boot_loader #(.SKIP_LOAD(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .cpu_reset (cpu_reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .load_err  (load_err),
        .loading   (loading)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        #1;
    endtask

    task automatic check_image(input string tag);
        for (int a = 0; a < 256; a++) begin
            chk($sformatf("%s_mem[%0d]", tag, a), {24'd0, mem[a]}, {24'd0, exp_mem[a]});
        end
    endtask

    // Offer one byte; it must be accepted on the next edge. Gap cycles follow with rx_valid low.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_data, input int addr);
        logic [7:0] a_hold;
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        chk("rx_ready_offer", {31'd0, rx_ready}, 32'd1);
        chk("mem_we_offer", {31'd0, mem_we}, {31'd0, is_data});
        if (is_data) begin
            chk("wr_addr", {24'd0, mem_addr}, addr);
            chk("wr_data", {24'd0, mem_wdata}, {24'd0, b});
            exp_mem[addr] = b;
        end
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        for (int g = 0; g < gap; g++) begin
            a_hold = mem_addr;
            tick();
            chk("gap_addr_stable", {24'd0, mem_addr}, {24'd0, a_hold});
            chk("gap_no_write", {31'd0, mem_we}, 32'd0);
        end
    endtask

    task automatic send_frame(input logic [7:0] lenb, input logic [7:0] cks, input int gap);
        int n;
        n = (lenb == 8'd0) ? 256 : int'(lenb);
        send_byte(lenb, gap, 1'b0, 0);
        for (int i = 0; i < n; i++) send_byte(pl[i], gap, 1'b1, i);
        send_byte(cks, 0, 1'b0, 0);
    endtask

    function automatic logic [7:0] model_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(pl[i]);
        return 8'(s % 256);
    endfunction

    initial begin
        logic [7:0] s;
        int n;
        bit bad;
        int gap;

        for (int a = 0; a < 256; a++) begin
            mem[a]     = 8'h00;
            exp_mem[a] = 8'h00;
        end
        reset     = 1'b1;
        load_req  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cpu_addr  = 8'h00;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        tick();
        tick();
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_loading", {31'd0, loading}, 32'd1);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;
        tick();

        // Gap-free 3-byte frame with good checksum.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(8'h03, 8'h66, 0);
        chk("f1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("f1_loading", {31'd0, loading}, 32'd0);
        chk("f1_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_image("f1");
        cpu_addr = 8'd1;
        #1;
        chk("f1_cpu_rdata", {24'd0, cpu_rdata}, {24'd0, exp_mem[1]});
        cpu_addr = 8'd0;

        // Same frame, bad checksum.
        pulse_load_req();
        send_frame(8'h03, 8'h67, 0);
        chk("f2_load_err", {31'd0, load_err}, 32'd1);
        chk("f2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("f2_loading", {31'd0, loading}, 32'd0);
        check_image("f2");
        pulse_load_req();
        chk("f2_relaunch_err", {31'd0, load_err}, 32'd0);
        chk("f2_relaunch_loading", {31'd0, loading}, 32'd1);

        // Length 0 means 256 bytes.
        for (int i = 0; i < 256; i++) pl[i] = 8'(i);
        s = model_sum(256);
        chk("model_sum256", {24'd0, s}, 32'h80);
        send_frame(8'h00, s, 0);
        chk("f3_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_image("f3");

        // Abort mid-DATA with a byte offered alongside load_req.
        pulse_load_req();
        send_byte(8'h03, 0, 1'b0, 0);
        send_byte(8'h11, 0, 1'b1, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        load_req = 1'b1;
        #1;
        chk("abort_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        load_req = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("abort_loading", {31'd0, loading}, 32'd1);
        pl[0] = 8'hAA;
        send_frame(8'h01, 8'hAA, 0);
        chk("abort_run", {31'd0, cpu_reset}, 32'd0);
        check_image("abort");

        // CPU write coincident with load_req commits; later CPU writes are blocked.
        cpu_addr  = 8'd10;
        cpu_wdata = 8'h5A;
        cpu_we    = 1'b1;
        load_req  = 1'b1;
        #1;
        chk("cpuwr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("cpuwr_addr", {24'd0, mem_addr}, 32'd10);
        exp_mem[10] = 8'h5A;
        tick();
        load_req = 1'b0;
        #1;
        chk("cpuwr_committed", {24'd0, mem[10]}, 32'h5A);
        chk("cpuwr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("cpuwr_blocked", {31'd0, mem_we}, 32'd0);
        cpu_we    = 1'b0;
        cpu_addr  = 8'd0;
        cpu_wdata = 8'd0;

        // Gapped frame, valid one cycle in four.
        pl[0] = 8'h01; pl[1] = 8'hFF;
        send_frame(8'h02, 8'h00, 3);
        chk("gap_run", {31'd0, cpu_reset}, 32'd0);
        chk("gap_loading", {31'd0, loading}, 32'd0);
        check_image("gap");

        // Random frames, random gaps, occasional corrupted checksum.
        for (int k = 0; k < 8; k++) begin
            pulse_load_req();
            n   = $urandom_range(1, 24);
            gap = $urandom_range(0, 2);
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) pl[i] = 8'($urandom_range(0, 255));
            s = model_sum(n);
            send_frame(8'(n), bad ? s + 8'd1 : s, gap);
            chk($sformatf("rnd%0d_cpu_reset", k), {31'd0, cpu_reset}, {31'd0, bad});
            chk($sformatf("rnd%0d_load_err", k), {31'd0, load_err}, {31'd0, bad});
            check_image($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
